sized_data_memory: RTL

- Byte-addressed, parametrised data memory for the pipelined datapath; next generation of the single-cycle DataMemory.
- Adds access sizes (byte/half/word/double) with zero or sign extension, little-endian byte lanes and write merging.
- Adds a request/done handshake with configurable latency and error reporting for misaligned, out-of-range or malformed accesses.
- Sits between the MEM-stage control and the register-file writeback mux; the stall logic watches Ready/Done.

---
 rtl/sized_mem_pkg.sv | 22 ++
 rtl/mem_lane_align.sv | 38 +++
 rtl/sized_data_memory.sv | 126 ++++++++++++
 3 files changed

// File: rtl/sized_mem_pkg.sv
// Shared types and helpers for the sized data memory: access size codes,
// FSM state encodings and the bytes-per-word log2 used for address decode.
package sized_mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE   = 2'd0,
    SIZE_HALF   = 2'd1,
    SIZE_WORD   = 2'd2,
    SIZE_DOUBLE = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;

  function automatic int bytes_log2(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: extracts/extends a sized read from a word
// and merges sized store data into a word, little-endian.
module mem_lane_align
  import sized_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int OFFW       = 3
) (
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic [OFFW-1:0]       offset_i,
  input  size_e                 size_i,
  input  logic                  sext_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [DATA_WIDTH-1:0] merged_o
);

  logic [DATA_WIDTH-1:0] shifted, keep, lanes;
  logic [6:0]            nbits;
  logic                  sgn;

  always_comb begin
    shifted = word_i >> {offset_i, 3'b000};
    nbits   = 7'd8 << size_i;
    // A shift by the full width yields zero, so keep becomes all ones for Size=max.
    keep    = ~({DATA_WIDTH{1'b1}} << nbits);
    case (size_i)
      SIZE_BYTE: sgn = shifted[7];
      SIZE_HALF: sgn = shifted[15];
      SIZE_WORD: sgn = shifted[31];
      default:   sgn = shifted[DATA_WIDTH-1];
    endcase
    rdata_o  = (shifted & keep) | ((sext_i && sgn) ? ~keep : '0);
    lanes    = keep << {offset_i, 3'b000};
    merged_o = (word_i & ~lanes) | ((wdata_i << {offset_i, 3'b000}) & lanes);
  end

endmodule

// File: rtl/sized_data_memory.sv
// Byte-addressed data memory with sized accesses, fixed-latency request/done
// handshake and error reporting for malformed, misaligned or out-of-range accesses.
module sized_data_memory
  import sized_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int LATENCY    = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Request,
  output logic                  Ready,
  input  logic                  MemoryRead,
  input  logic                  MemoryWrite,
  input  logic [1:0]            Size,
  input  logic                  SignExtend,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Done,
  output logic                  Error
);

  localparam int OFFW = bytes_log2(DATA_WIDTH);
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int HW   = ADDR_WIDTH - OFFW;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  rd_q, wr_q, sext_q;
  size_e                 size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  accept, exec, err_c;
  logic [OFFW-1:0]       off;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] rd_val, merged;

  assign accept = Request && (state_q == ST_IDLE);
  assign off    = addr_q[OFFW-1:0];
  assign idx    = addr_q[OFFW +: IW];

  // Comparing the whole field above the offset catches both idx >= DEPTH and stray high bits.
  assign err_c = (rd_q == wr_q)
              || (|(off & OFFW'((4'd1 << size_q) - 4'd1)))
              || (size_q == SIZE_DOUBLE && DATA_WIDTH == 32)
              || (addr_q[ADDR_WIDTH-1:OFFW] >= HW'(DEPTH));

  mem_lane_align #(.DATA_WIDTH(DATA_WIDTH), .OFFW(OFFW)) u_align (
    .word_i   (mem_q[idx]),
    .offset_i (off),
    .size_i   (size_q),
    .sext_i   (sext_q),
    .wdata_i  (wdata_q),
    .rdata_o  (rd_val),
    .merged_o (merged)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    exec    = 1'b0;
    case (state_q)
      ST_IDLE: if (Request) begin
        state_d = ST_WAIT;
        cnt_d   = CW'(LATENCY - 1);
      end
      ST_WAIT: if (cnt_q == '0) begin
        exec    = 1'b1;
        state_d = ST_RESPOND;
        err_d   = err_c;
        rdata_d = (err_c || wr_q) ? '0 : rd_val;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (accept) begin
      rd_q    <= MemoryRead;
      wr_q    <= MemoryWrite;
      size_q  <= size_e'(Size);
      sext_q  <= SignExtend;
      addr_q  <= Address;
      wdata_q <= WriteData;
    end
  end

  // Array has no reset; a write landing on a reset edge is dropped.
  always_ff @(posedge Clock) begin
    if (!Reset && exec && wr_q && !err_c) mem_q[idx] <= merged;
  end

  assign Ready    = (state_q == ST_IDLE);
  assign Done     = (state_q == ST_RESPOND);
  assign Error    = Done && err_q;
  assign ReadData = rdata_q;

endmodule
